// File: rtl/div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU: a 32-step FSM returning {remainder, quotient},
// with a combinational stall request while busy and annulment on flush.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 stallreq_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BYZERO,
        S_ON,
        S_END
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH:0]     work_q, work_d;
    logic [WIDTH-1:0]     divisor_q, divisor_d;
    logic                 neg_quot_q, neg_quot_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;

    logic                 op1_neg, op2_neg;
    logic [WIDTH-1:0]     abs1, abs2;
    logic [2*WIDTH:0]     shifted;
    logic [WIDTH+1:0]     trial;
    logic [WIDTH-1:0]     quot_w, rem_w;

    always_comb begin
        op1_neg = signed_div_i & opdata1_i[WIDTH-1];
        op2_neg = signed_div_i & opdata2_i[WIDTH-1];
        abs1    = op1_neg ? ({WIDTH{1'b0}} - opdata1_i) : opdata1_i;
        abs2    = op2_neg ? ({WIDTH{1'b0}} - opdata2_i) : opdata2_i;

        // Partial remainder lives in the upper 33 bits; a 34-bit trial exposes the borrow.
        shifted = {work_q[2*WIDTH-1:0], 1'b0};
        trial   = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, divisor_q};
        quot_w  = work_q[WIDTH-1:0];
        rem_w   = work_q[2*WIDTH-1:WIDTH];

        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            S_IDLE: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = S_BYZERO;
                    end else begin
                        state_d    = S_ON;
                        divisor_d  = abs2;
                        neg_quot_d = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_rem_d  = signed_div_i & opdata1_i[WIDTH-1];
                        work_d     = {{(WIDTH+1){1'b0}}, abs1};
                        cnt_d      = '0;
                    end
                end
            end
            S_BYZERO: begin
                if (annul_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_END;
                    result_d = '0;
                    ready_d  = 1'b1;
                end
            end
            S_ON: begin
                if (annul_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(WIDTH)) begin
                    state_d  = S_END;
                    ready_d  = 1'b1;
                    result_d = {neg_rem_q  ? ({WIDTH{1'b0}} - rem_w)  : rem_w,
                                neg_quot_q ? ({WIDTH{1'b0}} - quot_w) : quot_w};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (!trial[WIDTH+1])
                        work_d = {trial[WIDTH:0], shifted[WIDTH-1:1], 1'b1};
                    else
                        work_d = shifted;
                end
            end
            S_END: begin
                if (annul_i || !start_i) begin
                    state_d  = S_IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end
            default: begin
                state_d  = S_IDLE;
                ready_d  = 1'b0;
                result_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            work_q     <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    // Combinational so EX stalls in the very cycle it raises the request.
    assign stallreq_o = start_i & ~annul_i & ~ready_q;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: directed divides push expected results; a monitor
// pops and checks value and latency whenever ready_o rises.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i, opdata2_i;
    logic        start_i, annul_i;
    logic [63:0] result_o;
    logic        ready_o, stallreq_o;

    div_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
        .start_i(start_i), .annul_i(annul_i),
        .result_o(result_o), .ready_o(ready_o), .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    logic ready_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: on each ready_o rising edge, compare against the oldest expected result.
    always @(negedge clk) begin
        if (rst && ready_o && !ready_prev) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got result %h with empty scoreboard", result_o);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", result_o, e.res);
                chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                chk("stall_when_ready", {63'b0, stallreq_o}, 64'd0);
            end
        end
        ready_prev <= ready_o;
    end

    // Called at a negedge: present the request; the next posedge is the accept edge E0.
    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] res, input int lat);
        exp_t e;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        e.res = res;
        e.lat = lat;
        e.acc = cyc + 1;
        q.push_back(e);
        #1;
        chk("stall_request_cycle", {63'b0, stallreq_o}, 64'd1);
    endtask

    // Wait for ready, check stability for one cycle, then release and check return to idle.
    task automatic finish(input logic [63:0] res);
        bit seen = 0;
        @(negedge clk);
        opdata1_i = 32'hDEADBEEF;
        opdata2_i = 32'h00000003;
        for (int i = 0; i < 60; i++) begin
            if (ready_o) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got no ready_o expected ready within 60 cycles");
            start_i = 1'b0;
            @(negedge clk);
            return;
        end
        @(negedge clk);
        chk("ready_hold", {63'b0, ready_o}, 64'd1);
        chk("result_hold", result_o, res);
        start_i = 1'b0;
        @(negedge clk);
        chk("idle_ready", {63'b0, ready_o}, 64'd0);
        chk("idle_result", result_o, 64'd0);
    endtask

    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] res, input int lat);
        issue(sgn, a, b, res, lat);
        finish(res);
    endtask

    initial begin
        bit fired;
        rst = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        start_i = 1'b0;
        annul_i = 1'b0;
        #1;
        chk("reset_result", result_o, 64'd0);
        chk("reset_ready", {63'b0, ready_o}, 64'd0);
        chk("reset_stall", {63'b0, stallreq_o}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        do_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        do_div(1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
        do_div(1'b1, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 33);
        do_div(1'b0, 32'd5, 32'd0, 64'd0, 1);

        // Annul after the counter reaches 10.
        signed_div_i = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i = 1'b1;
        repeat (11) @(negedge clk);
        annul_i = 1'b1;
        #1;
        chk("stall_annul", {63'b0, stallreq_o}, 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        fired = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) fired = 1;
        end
        chk("annul_no_ready", {63'b0, fired}, 64'd0);
        do_div(1'b0, 32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF}, 33);

        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 33);
        do_div(1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'd0}, 33);

        // Asynchronous reset mid-ON, then a fresh divide with start held.
        signed_div_i = 1'b0;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i = 1'b1;
        repeat (21) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_on_ready", {63'b0, ready_o}, 64'd0);
        chk("async_rst_on_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        begin
            exp_t e;
            e.res = {32'd2, 32'd14};
            e.lat = 33;
            e.acc = cyc + 1;
            q.push_back(e);
        end
        finish({32'd2, 32'd14});

        // Asynchronous reset while a result is being presented.
        issue(1'b0, 32'd9, 32'd2, {32'd1, 32'd4}, 33);
        begin
            bit seen = 0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (ready_o) begin
                    seen = 1;
                    break;
                end
            end
            chk("end_reached", {63'b0, seen}, 64'd1);
        end
        #2 rst = 1'b0;
        #1;
        chk("async_rst_end_ready", {63'b0, ready_o}, 64'd0);
        chk("async_rst_end_result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
